// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Bus master that receives a framed byte stream
//               (sync, 16-bit word count, data words, XOR checksum) and
//               writes the words into tiny16 memory through the shared bus,
//               holding the CPU in reset while an image is being loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter logic [15:0] ADDR_START = 16'h0000,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [15:0] o_bus_out,
    output logic        o_bus_out_en,
    output logic        o_mem_addr_en,
    output logic        o_mem_in_en,
    output logic        o_cpu_hold,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_words_loaded
);

    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_WR_ADDR = 3'd5,
        S_WR_DATA = 3'd6,
        S_CHECK   = 3'd7
    } state_t;

    state_t      r_state;
    logic [15:0] r_count;
    logic [15:0] r_word;
    logic [15:0] r_addr;
    logic [7:0]  r_csum;
    logic [15:0] r_words_loaded;
    logic        r_cpu_hold;
    logic        r_done;
    logic        r_err;

    logic [15:0] r_bus_out;
    logic        r_bus_out_en;
    logic        r_mem_addr_en;
    logic        r_mem_in_en;

    logic        w_accept;
    logic [7:0]  w_csum_next;
    logic [15:0] w_len_full;
    logic [15:0] w_count_dec;

    // The two bus-write states never take a byte; reset also blocks intake.
    assign o_rx_ready  = rst_n && (r_state != S_WR_ADDR) && (r_state != S_WR_DATA);
    assign w_accept    = i_rx_valid && o_rx_ready;
    assign w_csum_next = r_csum ^ i_rx_data;
    assign w_len_full  = {r_count[15:8], i_rx_data};
    assign w_count_dec = r_count - 16'd1;

    // Frame parser / write sequencer; state, counters and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_SYNC;
            r_count        <= 16'd0;
            r_word         <= 16'd0;
            r_addr         <= ADDR_START;
            r_csum         <= 8'd0;
            r_words_loaded <= 16'd0;
            r_cpu_hold     <= 1'b1;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            case (r_state)
                S_SYNC: begin
                    // Non-sync bytes are consumed and dropped.
                    if (w_accept && (i_rx_data == SYNC_BYTE)) begin
                        r_state        <= S_LEN_HI;
                        r_csum         <= 8'd0;
                        r_words_loaded <= 16'd0;
                        r_addr         <= ADDR_START;
                        r_cpu_hold     <= 1'b1;
                        r_done         <= 1'b0;
                        r_err          <= 1'b0;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= i_rx_data;
                        r_csum        <= w_csum_next;
                        r_state       <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= i_rx_data;
                        r_csum       <= w_csum_next;
                        r_state      <= (w_len_full == 16'd0) ? S_CHECK : S_DATA_HI;
                    end
                end
                S_DATA_HI: begin
                    if (w_accept) begin
                        r_word[15:8] <= i_rx_data;
                        r_csum       <= w_csum_next;
                        r_state      <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (w_accept) begin
                        r_word[7:0] <= i_rx_data;
                        r_csum      <= w_csum_next;
                        r_state     <= S_WR_ADDR;
                    end
                end
                S_WR_ADDR: begin
                    r_state <= S_WR_DATA;
                end
                S_WR_DATA: begin
                    // Address wraps naturally at 16 bits.
                    r_addr         <= r_addr + 16'd1;
                    r_words_loaded <= r_words_loaded + 16'd1;
                    r_count        <= w_count_dec;
                    r_state        <= (w_count_dec == 16'd0) ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: begin
                    if (w_accept) begin
                        if (i_rx_data == r_csum) begin
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_SYNC;
                    end
                end
                default: r_state <= S_SYNC;
            endcase
        end
    end

    // Bus drive on the falling edge so values are settled for the memory's rising edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_out     <= 16'd0;
            r_bus_out_en  <= 1'b0;
            r_mem_addr_en <= 1'b0;
            r_mem_in_en   <= 1'b0;
        end else begin
            r_bus_out     <= 16'd0;
            r_bus_out_en  <= 1'b0;
            r_mem_addr_en <= 1'b0;
            r_mem_in_en   <= 1'b0;
            if (r_state == S_WR_ADDR) begin
                r_bus_out     <= r_addr;
                r_bus_out_en  <= 1'b1;
                r_mem_addr_en <= 1'b1;
            end else if (r_state == S_WR_DATA) begin
                r_bus_out    <= r_word;
                r_bus_out_en <= 1'b1;
                r_mem_in_en  <= 1'b1;
            end
        end
    end

    assign o_bus_out      = r_bus_out;
    assign o_bus_out_en   = r_bus_out_en;
    assign o_mem_addr_en  = r_mem_addr_en;
    assign o_mem_in_en    = r_mem_in_en;
    assign o_cpu_hold     = r_cpu_hold;
    assign o_busy         = (r_state != S_SYNC);
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader. A default
//               instance (ADDR_START=0) and a wrap instance (ADDR_START=FFFF)
//               share clock and reset; a byte sender feeds the selected one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        sel = 1'b0;

    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [15:0] a_bus, b_bus;
    logic        a_bus_en, b_bus_en;
    logic        a_aen, b_aen;
    logic        a_wen, b_wen;
    logic        a_hold, b_hold;
    logic        a_busy, b_busy;
    logic        a_done, b_done;
    logic        a_err, b_err;
    logic [15:0] a_wl, b_wl;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign a_valid = rx_valid && !sel;
    assign b_valid = rx_valid && sel;

    program_loader u_dut (
        .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(a_valid),
        .o_rx_ready(a_ready), .o_bus_out(a_bus), .o_bus_out_en(a_bus_en),
        .o_mem_addr_en(a_aen), .o_mem_in_en(a_wen), .o_cpu_hold(a_hold),
        .o_busy(a_busy), .o_done(a_done), .o_err(a_err), .o_words_loaded(a_wl)
    );

    program_loader #(.ADDR_START(16'hFFFF), .SYNC_BYTE(8'hA5)) u_wrap (
        .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(b_valid),
        .o_rx_ready(b_ready), .o_bus_out(b_bus), .o_bus_out_en(b_bus_en),
        .o_mem_addr_en(b_aen), .o_mem_in_en(b_wen), .o_cpu_hold(b_hold),
        .o_busy(b_busy), .o_done(b_done), .o_err(b_err), .o_words_loaded(b_wl)
    );

    // Write observers: {address, data} per write pair, seen at the memory's edge.
    logic [31:0] a_wq[$];
    logic [31:0] b_wq[$];
    logic [15:0] a_lat = 16'd0;
    logic [15:0] b_lat = 16'd0;
    int          both_hi = 0;
    int          b_stall = 0;

    always @(posedge clk) begin
        if (a_aen && a_wen) both_hi++;
        if (b_aen && b_wen) both_hi++;
        if (a_aen) a_lat = a_bus;
        if (a_wen) a_wq.push_back({a_lat, a_bus});
        if (b_aen) b_lat = b_bus;
        if (b_wen) b_wq.push_back({b_lat, b_bus});
    end

    always @(negedge clk) begin
        if (b_valid && !b_ready) b_stall++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present one byte and hold it until the selected loader accepts it.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sel ? b_ready : a_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
        rx_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_hold",  {31'd0, a_hold}, 32'd1);
        chk("rst_flags", {29'd0, a_busy, a_done, a_err}, 32'd0);
        chk("rst_wl",    {16'd0, a_wl}, 32'd0);
        chk("rst_strb",  {29'd0, a_bus_en, a_aen, a_wen}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic load
        a_wq.delete();
        send_frame('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42});
        chk("basic_nw",   a_wq.size(), 32'd2);
        chk("basic_w0",   a_wq[0], 32'h0000_1234);
        chk("basic_w1",   a_wq[1], 32'h0001_ABCD);
        chk("basic_stat", {28'd0, a_done, a_err, a_hold, a_busy}, 32'b1000);
        chk("basic_wl",   {16'd0, a_wl}, 32'd2);

        // Bad checksum
        a_wq.delete();
        send_frame('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43});
        chk("bad_nw",   a_wq.size(), 32'd2);
        chk("bad_w1",   a_wq[1], 32'h0001_ABCD);
        chk("bad_stat", {28'd0, a_done, a_err, a_hold, a_busy}, 32'b0110);
        chk("bad_rdy",  {31'd0, a_ready}, 32'd1);

        // Zero length, with leading junk
        a_wq.delete();
        send_frame('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00});
        chk("zero_nw",   a_wq.size(), 32'd0);
        chk("zero_stat", {28'd0, a_done, a_err, a_hold, a_busy}, 32'b1000);
        chk("zero_wl",   {16'd0, a_wl}, 32'd0);

        // Back-pressure and address wrap on the FFFF instance
        sel = 1'b1;
        b_stall = 0;
        b_wq.delete();
        send_frame('{8'hA5, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h02});
        chk("wrap_nw",    b_wq.size(), 32'd2);
        chk("wrap_w0",    b_wq[0], 32'hFFFF_1111);
        chk("wrap_w1",    b_wq[1], 32'h0000_2222);
        chk("wrap_stall", b_stall, 32'd4);
        chk("wrap_stat",  {28'd0, b_done, b_err, b_hold, b_busy}, 32'b1000);
        sel = 1'b0;

        // Mid-frame reset after the first data byte
        a_wq.delete();
        send_frame('{8'hA5, 8'h00, 8'h02, 8'h12});
        chk("mid_busy", {31'd0, a_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_stat", {28'd0, a_done, a_err, a_hold, a_busy}, 32'b0010);
        chk("mrst_strb", {28'd0, a_bus_en, a_aen, a_wen, a_ready}, 32'd0);
        chk("mrst_wl",   {16'd0, a_wl}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_nw", a_wq.size(), 32'd0);
        send_frame('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42});
        chk("resend_nw",   a_wq.size(), 32'd2);
        chk("resend_w0",   a_wq[0], 32'h0000_1234);
        chk("resend_stat", {28'd0, a_done, a_err, a_hold, a_busy}, 32'b1000);

        // Reload after done
        a_wq.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("idle_hold", {31'd0, a_hold}, 32'd0);
        send_byte(8'hA5);
        chk("reload_sync", {28'd0, a_done, a_err, a_hold, a_busy}, 32'b0011);
        send_frame('{8'h00, 8'h01, 8'h56, 8'h78, 8'h2F});
        chk("reload_nw",   a_wq.size(), 32'd1);
        chk("reload_w0",   a_wq[0], 32'h0000_5678);
        chk("reload_stat", {28'd0, a_done, a_err, a_hold, a_busy}, 32'b1000);
        chk("reload_wl",   {16'd0, a_wl}, 32'd1);

        chk("strobe_excl", both_hi, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
